// File: rtl/udar_pkg.sv
// Shared types and constants for the UDAR grid-scan scheduler.
package udar_pkg;

  localparam int unsigned POS_LEN         = 8;
  localparam int unsigned CAP_LEN         = 16;
  localparam int unsigned SETTLE_LEN      = 16;
  localparam int unsigned TICK_DIV_DEF    = 50;
  localparam int unsigned RANGE_TO_US_DEF = 1300;

  localparam logic [POS_LEN-1:0] PARK_POS = POS_LEN'(150);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_TRIG,
    S_WAIT,
    S_EMIT,
    S_STEP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [POS_LEN-1:0] x;
    logic [POS_LEN-1:0] y;
    logic [CAP_LEN-1:0] len;
    logic               to;
  } rec_t;

  // A window is usable when both axes are ordered and the step is non-zero.
  function automatic logic cfg_valid(input logic [POS_LEN-1:0] x_min,
                                     input logic [POS_LEN-1:0] x_max,
                                     input logic [POS_LEN-1:0] y_min,
                                     input logic [POS_LEN-1:0] y_max,
                                     input logic [POS_LEN-1:0] step);
    return (x_min <= x_max) && (y_min <= y_max) && (step != '0);
  endfunction

endpackage

// File: rtl/udar_us_timer.sv
// Microsecond timer: TICK_DIV clock divider feeding a us counter with clear and compare.
module udar_us_timer #(
  parameter int unsigned TICK_DIV = 50,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] cmp,
  output logic             hit_c
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_us;
  logic             w_tick;

  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));
  assign hit_c  = (r_us == cmp);

  // Divider and us count; clear restarts both so the first tick is a full microsecond.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_div <= '0;
      r_us  <= '0;
    end else if (clr) begin
      r_div <= '0;
      r_us  <= '0;
    end else if (en) begin
      if (w_tick) begin
        r_div <= '0;
        r_us  <= r_us + CNT_W'(1);
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/udar_scan_sched.sv
// Grid-scan scheduler: steps servo X/Y over a window, settles, ranges and emits one record per point.
// Build option: define SCAN_SERPENTINE_EN for boustrophedon order (raster otherwise).
module udar_scan_sched
  import udar_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned RANGE_TO_US = RANGE_TO_US_DEF
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start,
  input  logic                  abort,
  input  logic [POS_LEN-1:0]    cfg_x_min,
  input  logic [POS_LEN-1:0]    cfg_x_max,
  input  logic [POS_LEN-1:0]    cfg_y_min,
  input  logic [POS_LEN-1:0]    cfg_y_max,
  input  logic [POS_LEN-1:0]    cfg_step,
  input  logic [SETTLE_LEN-1:0] cfg_settle,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [POS_LEN-1:0]    pos_x,
  output logic [POS_LEN-1:0]    pos_y,
  output logic                  rng_en,
  input  logic                  rng_done,
  input  logic [CAP_LEN-1:0]    rng_len,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [POS_LEN-1:0]    rec_x,
  output logic [POS_LEN-1:0]    rec_y,
  output logic [CAP_LEN-1:0]    rec_len,
  output logic                  rec_to
);

  state_t                r_state, w_nxt;
  logic [POS_LEN-1:0]    r_x_min, r_x_max, r_y_max, r_step;
  logic [SETTLE_LEN-1:0] r_settle;
  logic [POS_LEN-1:0]    r_pos_x, r_pos_y;
  rec_t                  r_rec;
  logic                  r_rec_valid, r_rng_en, r_done, r_cfg_err, r_busy;
  logic                  w_hit, w_tmr_clr, w_tmr_en, w_cfg_ok, w_row_end, w_y_over;
  logic [SETTLE_LEN-1:0] w_cmp;
  logic [POS_LEN:0]      w_up, w_ny;
  logic [POS_LEN-1:0]    w_nx;
`ifdef SCAN_SERPENTINE_EN
  logic                  r_dir;
  logic [POS_LEN:0]      w_dn;
`endif

  udar_us_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (SETTLE_LEN)
  ) u_timer (
    .clk   (clk),
    .rst_i (rst_i),
    .clr   (w_tmr_clr),
    .en    (w_tmr_en),
    .cmp   (w_cmp),
    .hit_c (w_hit)
  );

  // Timer control and next-grid-point arithmetic (one guard bit so overflow reads as "past max").
  always_comb begin
    w_tmr_clr = (r_state == S_MOVE) || (r_state == S_TRIG);
    w_tmr_en  = (r_state == S_SETTLE) || (r_state == S_WAIT);
    w_cmp     = (r_state == S_WAIT) ? SETTLE_LEN'(RANGE_TO_US) : r_settle;
    w_cfg_ok  = cfg_valid(cfg_x_min, cfg_x_max, cfg_y_min, cfg_y_max, cfg_step);
    w_up      = {1'b0, r_pos_x} + {1'b0, r_step};
    w_ny      = {1'b0, r_pos_y} + {1'b0, r_step};
    w_y_over  = (w_ny > {1'b0, r_y_max});
`ifdef SCAN_SERPENTINE_EN
    w_dn      = {1'b0, r_pos_x} - {1'b0, r_step};
    if (r_dir) begin
      w_row_end = w_dn[POS_LEN] || (w_dn[POS_LEN-1:0] < r_x_min);
      w_nx      = w_row_end ? r_pos_x : w_dn[POS_LEN-1:0];
    end else begin
      w_row_end = (w_up > {1'b0, r_x_max});
      w_nx      = w_row_end ? r_pos_x : w_up[POS_LEN-1:0];
    end
`else
    w_row_end = (w_up > {1'b0, r_x_max});
    w_nx      = w_row_end ? r_x_min : w_up[POS_LEN-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start && w_cfg_ok) w_nxt = S_MOVE;
      S_MOVE:   w_nxt = S_SETTLE;
      S_SETTLE: if (w_hit) w_nxt = S_TRIG;
      S_TRIG:   w_nxt = S_WAIT;
      S_WAIT:   if (rng_done || w_hit) w_nxt = S_EMIT;
      S_EMIT:   if (rec_ready) w_nxt = S_STEP;
      S_STEP:   w_nxt = (w_row_end && w_y_over) ? S_DONE : S_MOVE;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
    if (abort) w_nxt = S_IDLE;
  end

  // Registered outputs, latched config, current point and record capture.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_x_min     <= '0;
      r_x_max     <= '0;
      r_y_max     <= '0;
      r_step      <= '0;
      r_settle    <= '0;
      r_pos_x     <= PARK_POS;
      r_pos_y     <= PARK_POS;
      r_rec       <= '0;
      r_rec_valid <= 1'b0;
      r_rng_en    <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SCAN_SERPENTINE_EN
      r_dir       <= 1'b0;
`endif
    end else begin
      r_rng_en    <= (w_nxt == S_TRIG);
      r_done      <= (w_nxt == S_DONE);
      r_busy      <= (w_nxt != S_IDLE);
      r_rec_valid <= (w_nxt == S_EMIT);
      r_cfg_err   <= (r_state == S_IDLE) && start && !abort && !w_cfg_ok;
      case (r_state)
        S_IDLE: begin
`ifdef SCAN_SERPENTINE_EN
          r_dir <= 1'b0;
`endif
          if (w_nxt == S_MOVE) begin
            r_x_min  <= cfg_x_min;
            r_x_max  <= cfg_x_max;
            r_y_max  <= cfg_y_max;
            r_step   <= cfg_step;
            r_settle <= cfg_settle;
            r_pos_x  <= cfg_x_min;
            r_pos_y  <= cfg_y_min;
          end
        end
        S_WAIT: begin
          if (w_nxt == S_EMIT) begin
            r_rec.x   <= r_pos_x;
            r_rec.y   <= r_pos_y;
            r_rec.len <= rng_done ? rng_len : '1;
            r_rec.to  <= !rng_done;
          end
        end
        S_STEP: begin
          if (w_nxt == S_MOVE) begin
            r_pos_x <= w_nx;
            if (w_row_end) begin
              r_pos_y <= w_ny[POS_LEN-1:0];
`ifdef SCAN_SERPENTINE_EN
              r_dir   <= !r_dir;
`endif
            end
          end
        end
        default: ;
      endcase
      if ((w_nxt == S_IDLE) || (w_nxt == S_DONE)) begin
        r_pos_x <= PARK_POS;
        r_pos_y <= PARK_POS;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign rng_en    = r_rng_en;
  assign rec_valid = r_rec_valid;
  assign rec_x     = r_rec.x;
  assign rec_y     = r_rec.y;
  assign rec_len   = r_rec.len;
  assign rec_to    = r_rec.to;

endmodule

// File: tb/tb_udar_scan_sched.sv
// Testbench for udar_scan_sched: randomized scans checked against a point-list model.
module tb_udar_scan_sched;

  localparam int DIV   = 4;
  localparam int TO_US = 1300;
`ifdef SCAN_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  logic        clk;
  logic        rst_i;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_x_min, cfg_x_max, cfg_y_min, cfg_y_max, cfg_step;
  logic [15:0] cfg_settle;
  logic        busy, done, cfg_err;
  logic [7:0]  pos_x, pos_y;
  logic        rng_en;
  logic        rng_done;
  logic [15:0] rng_len;
  logic        rec_valid;
  logic        rec_ready;
  logic [7:0]  rec_x, rec_y;
  logic [15:0] rec_len;
  logic        rec_to;

  udar_scan_sched #(.TICK_DIV(DIV), .RANGE_TO_US(TO_US)) dut (
    .clk(clk), .rst_i(rst_i), .start(start), .abort(abort),
    .cfg_x_min(cfg_x_min), .cfg_x_max(cfg_x_max), .cfg_y_min(cfg_y_min), .cfg_y_max(cfg_y_max),
    .cfg_step(cfg_step), .cfg_settle(cfg_settle),
    .busy(busy), .done(done), .cfg_err(cfg_err), .pos_x(pos_x), .pos_y(pos_y),
    .rng_en(rng_en), .rng_done(rng_done), .rng_len(rng_len),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_x(rec_x), .rec_y(rec_y), .rec_len(rec_len), .rec_to(rec_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int x; int y; int len; int to; } rec_s;

  rec_s got_q[$];
  rec_s exp_q[$];
  int   exp_len_q[$];
  int   sp_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_rng = 0, rng_dbl = 0, n_done = 0, n_err = 0, n_busy = 0, unstable = 0, last_rng = 0;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_rng = 1'b0;
  logic [32:0] p_rec = '0;
  int rng_mode = 1;
  int ready_mode = 0;
  int base_got, base_len, base_sp, base_done, base_rng;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: collects accepted records, pulses and stability of held records.
  always @(negedge clk) begin
    if (rec_valid && rec_ready)
      got_q.push_back(rec_s'{x: int'(rec_x), y: int'(rec_y), len: int'(rec_len), to: int'(rec_to)});
    if (rec_valid && p_valid && !p_ready && ({rec_x, rec_y, rec_len, rec_to} != p_rec))
      unstable <= unstable + 1;
    if (rng_en) begin
      n_rng    <= n_rng + 1;
      last_rng <= cyc;
      if (p_rng) rng_dbl <= rng_dbl + 1;
    end
    if (rec_valid && !p_valid) sp_q.push_back(cyc - last_rng);
    if (done)    n_done <= n_done + 1;
    if (cfg_err) n_err  <= n_err + 1;
    if (busy)    n_busy <= n_busy + 1;
    p_valid <= rec_valid;
    p_ready <= rec_ready;
    p_rng   <= rng_en;
    p_rec   <= {rec_x, rec_y, rec_len, rec_to};
  end

  // Ranging responder: answers 10 us after each trigger when enabled.
  initial begin
    rng_done = 1'b0;
    rng_len  = '0;
    forever begin
      @(negedge clk);
      if (rng_en && rng_mode == 0) begin
        repeat (10 * DIV) @(posedge clk);
        #1;
        rng_len  = 16'($urandom);
        rng_done = 1'b1;
        exp_len_q.push_back(int'(rng_len));
        @(posedge clk);
        #1 rng_done = 1'b0;
      end
    end
  end

  // Record sink: always ready, stalled, or random.
  initial begin
    rec_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rec_ready = 1'b1;
        1:       rec_ready = 1'b0;
        default: rec_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference: the expected visit order, built directly from the scan rules.
  task automatic model_points(input int xmin, input int xmax, input int ymin, input int ymax,
                              input int step);
    int x, nx;
    bit rev;
    exp_q.delete();
    x   = xmin;
    rev = 1'b0;
    for (int y = ymin; y <= ymax; y += step) begin
      if (!SERP) x = xmin;
      forever begin
        exp_q.push_back(rec_s'{x: x, y: y, len: 0, to: 0});
        nx = rev ? x - step : x + step;
        if (nx < xmin || nx > xmax) break;
        x = nx;
      end
      if (SERP) rev = !rev;
    end
  endtask

  task automatic start_scan(input int xmin, input int xmax, input int ymin, input int ymax,
                            input int step, input int settle, input int rmode);
    model_points(xmin, xmax, ymin, ymax, step);
    base_got  = got_q.size();
    base_len  = exp_len_q.size();
    base_sp   = sp_q.size();
    base_done = n_done;
    base_rng  = n_rng;
    rng_mode  = rmode;
    @(posedge clk); #1;
    cfg_x_min  = 8'(xmin);
    cfg_x_max  = 8'(xmax);
    cfg_y_min  = 8'(ymin);
    cfg_y_max  = 8'(ymax);
    cfg_step   = 8'(step);
    cfg_settle = 16'(settle);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    cfg_x_min  = 8'($urandom);
    cfg_x_max  = 8'($urandom);
    cfg_y_min  = 8'($urandom);
    cfg_y_max  = 8'($urandom);
    cfg_step   = 8'($urandom);
    cfg_settle = 16'($urandom_range(0, 50));
  endtask

  task automatic finish_scan(input string tag, input int rmode);
    int b = 0;
    int elen, eto;
    rec_s r;
    while (n_done == base_done && b < 30000) begin @(negedge clk); b++; end
    n_chk++;
    if (n_done == base_done) $display("FAIL %s done_timeout: no done within %0d cycles", tag, b);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (n_done - base_done != 1) $display("FAIL %s done_count: got %0d want 1", tag, n_done - base_done);
    else n_pass++;
    n_chk++;
    if (got_q.size() - base_got != exp_q.size())
      $display("FAIL %s rec_count: got %0d want %0d", tag, got_q.size() - base_got, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_got + i < got_q.size()) begin
        r    = got_q[base_got + i];
        eto  = (rmode == 0) ? 0 : 1;
        elen = 65535;
        if (rmode == 0) elen = (base_len + i < exp_len_q.size()) ? exp_len_q[base_len + i] : -1;
        n_chk++;
        if (r.x != exp_q[i].x || r.y != exp_q[i].y || r.len != elen || r.to != eto)
          $display("FAIL %s rec%0d: got (%0d,%0d) len %0d to %0d want (%0d,%0d) len %0d to %0d",
                   tag, i, r.x, r.y, r.len, r.to, exp_q[i].x, exp_q[i].y, elen, eto);
        else n_pass++;
      end
    end
    n_chk++;
    if (pos_x !== 8'd150 || pos_y !== 8'd150 || busy !== 1'b0)
      $display("FAIL %s park: got pos (%0d,%0d) busy %b want (150,150) busy 0", tag, pos_x, pos_y, busy);
    else n_pass++;
    n_chk++;
    if (rng_dbl != 0) $display("FAIL %s rng_en_width: got %0d multi-cycle pulses want 0", tag, rng_dbl);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_x_min = '0; cfg_x_max = '0; cfg_y_min = '0; cfg_y_max = '0; cfg_step = '0; cfg_settle = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (pos_x !== 8'd150 || pos_y !== 8'd150)
      $display("FAIL reset_pos: got (%0d,%0d) want (150,150)", pos_x, pos_y);
    else n_pass++;
    n_chk++;
    if ({busy, done, cfg_err, rng_en, rec_valid} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {busy, done, cfg_err, rng_en, rec_valid});
    else n_pass++;
    n_chk++;
    if ({rec_x, rec_y, rec_len, rec_to} !== 33'b0)
      $display("FAIL reset_rec: got %h want 0", {rec_x, rec_y, rec_len, rec_to});
    else n_pass++;
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    start_scan(100, 110, 50, 50, 5, 2, 0);
    finish_scan("basic", 0);
  endtask

  task automatic test_timeout();
    int lo = TO_US * DIV;
    start_scan(0, 10, 0, 10, 10, 0, 1);
    finish_scan("timeout", 1);
    n_chk++;
    if (sp_q.size() - base_sp != 4) $display("FAIL timeout_spacing_count: got %0d want 4", sp_q.size() - base_sp);
    else n_pass++;
    for (int i = base_sp; i < sp_q.size(); i++) begin
      n_chk++;
      if (sp_q[i] < lo || sp_q[i] > lo + 3)
        $display("FAIL timeout_spacing%0d: got %0d cycles want %0d..%0d", i - base_sp, sp_q[i], lo, lo + 3);
      else n_pass++;
    end
  endtask

  task automatic test_column();
    start_scan(250, 255, 240, 255, 8, 1, 0);
    finish_scan("column", 0);
  endtask

  task automatic test_backpressure();
    int b = 0;
    int snap_rng, snap_uns;
    ready_mode = 1;
    start_scan(10, 20, 5, 5, 10, 1, 0);
    while (!rec_valid && b < 3000) begin @(negedge clk); b++; end
    snap_rng = n_rng;
    snap_uns = unstable;
    repeat (40) @(negedge clk);
    n_chk++;
    if (rec_valid !== 1'b1 || rec_x !== 8'd10 || rec_y !== 8'd5)
      $display("FAIL bp_hold: got valid %b (%0d,%0d) want valid 1 (10,5)", rec_valid, rec_x, rec_y);
    else n_pass++;
    n_chk++;
    if (n_rng != snap_rng || unstable != snap_uns)
      $display("FAIL bp_stall: got %0d rng_en %0d changes want 0 0", n_rng - snap_rng, unstable - snap_uns);
    else n_pass++;
    ready_mode = 0;
    finish_scan("backpressure", 0);
  endtask

  task automatic abort_pulse();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int b = 0;
    int g0;
    start_scan(30, 60, 30, 60, 10, 0, 0);
    while (!rng_en && b < 3000) begin @(negedge clk); b++; end
    repeat (3) @(negedge clk);
    g0 = got_q.size();
    abort_pulse();
    n_chk++;
    if ({busy, rec_valid, rng_en} !== 3'b0 || pos_x !== 8'd150 || pos_y !== 8'd150)
      $display("FAIL abort_wait: got busy/valid/en %b pos (%0d,%0d) want 000 (150,150)",
               {busy, rec_valid, rng_en}, pos_x, pos_y);
    else n_pass++;
    repeat (80) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || n_done != base_done || got_q.size() != g0)
      $display("FAIL abort_late_done: got busy %b done %0d recs %0d want 0 0 0",
               busy, n_done - base_done, got_q.size() - g0);
    else n_pass++;
    ready_mode = 1;
    start_scan(30, 60, 30, 60, 10, 0, 0);
    b = 0;
    while (!rec_valid && b < 3000) begin @(negedge clk); b++; end
    repeat (5) @(negedge clk);
    abort_pulse();
    n_chk++;
    if (rec_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_emit: got valid %b busy %b want 0 0", rec_valid, busy);
    else n_pass++;
    ready_mode = 0;
    repeat (10) @(negedge clk);
    n_chk++;
    if (n_done != base_done) $display("FAIL abort_no_done: got %0d done pulses want 0", n_done - base_done);
    else n_pass++;
    start_scan(5, 15, 5, 5, 5, 0, 0);
    finish_scan("restart", 0);
  endtask

  task automatic test_cfg_err();
    int e0, b0, r0;
    for (int k = 0; k < 3; k++) begin
      e0 = n_err; b0 = n_busy; r0 = n_rng;
      @(posedge clk); #1;
      cfg_x_min = (k == 0) ? 8'd20 : 8'd0;
      cfg_x_max = 8'd10;
      cfg_y_min = (k == 2) ? 8'd40 : 8'd0;
      cfg_y_max = 8'd10;
      cfg_step  = (k == 1) ? 8'd0 : 8'd5;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(negedge clk);
      n_chk++;
      if (n_err - e0 != 1 || n_busy != b0 || n_rng != r0)
        $display("FAIL cfg_err%0d: got err %0d busy %0d rng %0d want 1 0 0", k, n_err - e0, n_busy - b0, n_rng - r0);
      else n_pass++;
    end
  endtask

  task automatic test_grid2x2();
    int ex[4], ey[4];
    int g0;
    ex[0] = 0; ey[0] = 0; ex[1] = 10; ey[1] = 0;
    ex[2] = SERP ? 10 : 0; ey[2] = 10;
    ex[3] = SERP ? 0 : 10; ey[3] = 10;
    start_scan(0, 10, 0, 10, 10, 0, 0);
    g0 = base_got;
    finish_scan("grid", 0);
    for (int i = 0; i < 4; i++) begin
      if (g0 + i < got_q.size()) begin
        n_chk++;
        if (got_q[g0 + i].x != ex[i] || got_q[g0 + i].y != ey[i])
          $display("FAIL grid_order%0d: got (%0d,%0d) want (%0d,%0d)", i, got_q[g0 + i].x, got_q[g0 + i].y, ex[i], ey[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int xmin, xmax, ymin, ymax, step, settle;
    ready_mode = 2;
    for (int k = 0; k < 4; k++) begin
      xmin   = $urandom_range(0, 250);
      xmax   = xmin + $urandom_range(0, 40);
      if (xmax > 255) xmax = 255;
      ymin   = $urandom_range(0, 250);
      ymax   = ymin + $urandom_range(0, 30);
      if (ymax > 255) ymax = 255;
      step   = $urandom_range(6, 30);
      settle = $urandom_range(0, 3);
      start_scan(xmin, xmax, ymin, ymax, step, settle, 0);
      finish_scan("random", 0);
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_column();
    test_backpressure();
    test_abort();
    test_cfg_err();
    test_grid2x2();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
